// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption core: one Feistel round per clock, subkeys K16..K1
// derived on the fly by right-rotating C/D from the unrotated PC-1 output.
module des_decrypt_iter #(
    parameter int unsigned ZERO_IDLE_OUT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] data_in,
    input  logic [63:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] data_out,
    output logic        busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready is high only in IDLE, out_valid only in DONE.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Table entries are DES bit numbers (1 = MSB of the source vector).
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7
    };
    localparam int FP_T [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25
    };
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };
    // Each box is flattened row-major: index = {row, column}.
    localparam int SBOX [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    function automatic logic [55:0] pc1_perm(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++) o[6'(55 - i)] = k[6'(64 - PC1_T[i])];
        return o;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] cd);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
        return o;
    endfunction

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[6'(63 - i)] = x[6'(64 - IP_T[i])];
        return o;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[6'(63 - i)] = x[6'(64 - FP_T[i])];
        return o;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[6'(47 - i)] = x[5'(32 - E_T[i])];
        return o;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] o;
        o = '0;
        for (int i = 0; i < 32; i++) o[5'(31 - i)] = x[5'(32 - P_T[i])];
        return o;
    endfunction

    function automatic logic [31:0] s_sub(input logic [47:0] x);
        logic [31:0] o;
        logic [5:0]  six;
        o = '0;
        for (int j = 0; j < 8; j++) begin
            six = x[6'(47 - 6 * j) -: 6];
            o[5'(31 - 4 * j) -: 4] = 4'(SBOX[3'(j)][{six[5], six[0], six[4:1]}]);
        end
        return o;
    endfunction

    logic [1:0]  state;
    logic [3:0]  rnd;
    logic [31:0] l, r;
    logic [27:0] c, d;

    logic [47:0] k_sub;
    logic [31:0] f_out, l_nxt, r_nxt;
    logic [1:0]  rot_amt;
    logic [27:0] c_rot, d_rot;

    always_comb begin
        k_sub = pc2_perm({c, d});
        f_out = p_perm(s_sub(e_expand(r) ^ k_sub));
        l_nxt = r;
        r_nxt = l ^ f_out;
        // Right rotations undo the encryption left shifts, walking C16/D16 back to C1/D1.
        case (rnd)
            4'd0, 4'd7, 4'd14: rot_amt = 2'd1;
            4'd15:             rot_amt = 2'd0;
            default:           rot_amt = 2'd2;
        endcase
        case (rot_amt)
            2'd1:    begin c_rot = {c[0], c[27:1]};   d_rot = {d[0], d[27:1]};   end
            2'd2:    begin c_rot = {c[1:0], c[27:2]}; d_rot = {d[1:0], d[27:2]}; end
            default: begin c_rot = c;                 d_rot = d;                 end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rnd      <= 4'd0;
            l        <= '0;
            r        <= '0;
            c        <= '0;
            d        <= '0;
            data_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        {l, r} <= ip_perm(data_in);
                        {c, d} <= pc1_perm(key);
                        rnd    <= 4'd0;
                        state  <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    l   <= l_nxt;
                    r   <= r_nxt;
                    c   <= c_rot;
                    d   <= d_rot;
                    rnd <= rnd + 4'd1;
                    if (rnd == 4'd15) begin
                        // Final halves are swapped before FP.
                        data_out <= fp_perm({r_nxt, l_nxt});
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                        if (ZERO_IDLE_OUT != 0) data_out <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_ROUND) || (state == ST_DONE);

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Bench for des_decrypt_iter: known-answer vectors plus random round trips
// through a textbook DES model (left-shift key schedule, subkeys in an array).
module tb_des_decrypt_iter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] data_in;
    logic [63:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] data_out;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    des_decrypt_iter #(.ZERO_IDLE_OUT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in), .key(key),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .busy(busy)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    localparam int M_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int M_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
        26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int M_IP [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};
    localparam int M_FP [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};
    localparam int M_E [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int M_P [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int M_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int M_S [8][4][16] = '{
        '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
          '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
        '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
          '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
        '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
          '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
        '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
          '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
        '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
          '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
        '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
          '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
        '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
          '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
        '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
          '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
    };

    // DES bit n (1-based, MSB first) of a w-bit value held right-aligned in v.
    function automatic logic dbit(input logic [63:0] v, input int w, input int n);
        return v[6'(w - n)];
    endfunction

    function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] o;
        logic [5:0]  six;
        x = '0; s = '0; o = '0;
        for (int i = 0; i < 48; i++) x = {x[46:0], dbit({32'b0, r}, 32, M_E[i])};
        x = x ^ k;
        for (int j = 0; j < 8; j++) begin
            six = 6'(x >> (42 - 6 * j));
            s = {s[27:0], 4'(M_S[j][{six[5], six[0]}][six[4:1]])};
        end
        for (int i = 0; i < 32; i++) o = {o[30:0], dbit({32'b0, s}, 32, M_P[i])};
        return o;
    endfunction

    function automatic logic [63:0] des_model(input logic [63:0] blk, input logic [63:0] k,
                                              input bit decrypt);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [63:0] x, o;
        logic [31:0] l, r, t;
        cd = '0; x = '0; o = '0;
        for (int i = 0; i < 56; i++) cd = {cd[54:0], dbit(k, 64, M_PC1[i])};
        c = cd[55:28]; d = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < M_SHIFT[i]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            ks[i] = '0;
            for (int b = 0; b < 48; b++) ks[i] = {ks[i][46:0], dbit({8'b0, c, d}, 56, M_PC2[b])};
        end
        for (int i = 0; i < 64; i++) x = {x[62:0], dbit(blk, 64, M_IP[i])};
        l = x[63:32]; r = x[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ m_f(r, decrypt ? ks[15 - i] : ks[i]);
            l = t;
        end
        for (int i = 0; i < 64; i++) o = {o[62:0], dbit({r, l}, 64, M_FP[i])};
        return o;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Offers one block and returns #1 after the accepting edge.
    task automatic send_block(input logic [63:0] ct, input logic [63:0] k, input logic [63:0] pt);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("send_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        data_in  = ct;
        key      = k;
        exp_q.push_back(pt);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in  = {$urandom, $urandom};
        key      = {$urandom, $urandom};
    endtask

    // Called right after the accept edge: cycle 1 is the one following that edge.
    task automatic wait_out(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("out_valid_seen", 64'(out_valid), 64'd1);
    endtask

    task automatic take_out(input string tag);
        logic [63:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        check(tag, data_out, exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_hs_out_valid", 64'(out_valid), 64'd0);
        check("post_hs_in_ready", 64'(in_ready), 64'd1);
        check("post_hs_data_zero", data_out, 64'd0);
    endtask

    // ---------------- main sequence ----------------
    localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
    localparam logic [63:0] CT1 = 64'h85E813540F0AB405;
    localparam logic [63:0] PT1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] PT2 = 64'h8787878787878787;
    localparam logic [63:0] KW  = 64'h0101010101010101;
    localparam logic [63:0] CTW = 64'h8CA64DE9C1B123A7;

    initial begin
        int cyc;
        int seen;
        int last_t;
        int idx;
        int n_out;
        logic acc;
        logic [63:0] s_pt [4];
        logic [63:0] s_key [4];
        logic [63:0] pt, kk;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = '0; key = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data_out", data_out, 64'd0);

        // Known answer with latency: plaintext appears in cycle 17 after the accept edge.
        send_block(CT1, K1, PT1);
        check("busy_in_round", 64'(busy), 64'd1);
        check("in_ready_in_round", 64'(in_ready), 64'd0);
        wait_out(cyc);
        check("latency_cycles", 64'(cyc), 64'd17);
        take_out("kat1_data");

        send_block(64'd0, K2, PT2);
        wait_out(cyc);
        take_out("kat2_data");

        send_block(64'd0, K2 ^ 64'h0101010101010101, PT2);
        wait_out(cyc);
        take_out("kat2_parity_flip");

        send_block(CTW, KW, 64'd0);
        wait_out(cyc);
        take_out("weak_key");

        // Backpressure with stray in_valid pulses that must be ignored.
        send_block(64'd0, K2, PT2);
        wait_out(cyc);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            data_in  = {$urandom, $urandom};
            key      = {$urandom, $urandom};
            @(posedge clk);
            #1;
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_data_out", data_out, PT2);
        end
        in_valid = 1'b0;
        take_out("bp_release");
        @(posedge clk);
        #1;
        check("bp_nothing_queued", 64'(busy), 64'd0);

        // Reset during round 8 abandons the block.
        send_block(CT1, K1, PT1);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        void'(exp_q.pop_front());
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_data_out", data_out, 64'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst_no_valid", 64'(seen), 64'd0);
        send_block(CT1, K1, PT1);
        wait_out(cyc);
        take_out("after_rst_kat1");

        // Random round trips with a random consumer stall.
        for (int n = 0; n < 6; n++) begin
            pt = {$urandom, $urandom};
            kk = {$urandom, $urandom};
            send_block(des_model(pt, kk, 1'b0), kk, pt);
            wait_out(cyc);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            check("rand_still_valid", 64'(out_valid), 64'd1);
            take_out("rand_roundtrip");
        end

        // Streaming: in_valid and out_ready held high, four blocks.
        for (int n = 0; n < 4; n++) begin
            s_pt[n]  = {$urandom, $urandom};
            s_key[n] = {$urandom, $urandom};
        end
        idx = 0; n_out = 0; last_t = -1; cyc = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        data_in   = des_model(s_pt[0], s_key[0], 1'b0);
        key       = s_key[0];
        out_ready = 1'b1;
        while (n_out < 4 && cyc < 200) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            acc = in_ready && in_valid;
            if (acc) exp_q.push_back(s_pt[idx]);
            if (out_valid) begin
                check("stream_data", data_out, (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx);
                if (last_t >= 0) check("stream_spacing", 64'(cyc - last_t), 64'd18);
                last_t = cyc;
                n_out++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    data_in = des_model(s_pt[idx], s_key[idx], 1'b0);
                    key     = s_key[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("stream_count", 64'(n_out), 64'd4);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
